rv32im_muldiv_unit: RTL and testbench

- Multi-cycle execute-stage unit for the RV32 M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the combinational ALU. It is selected when opcode = 0110011 and funct7 = 0000001.
- Accepts one operation at a time through a valid/ready handshake and returns a one-cycle result pulse.
- The pipeline stalls the issuing instruction while o_ready is low.

---
 rtl/rv32im_muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_rv32im_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_muldiv_unit.sv
// Multi-cycle RV32 M-extension unit: pipelined multiply, restoring divide,
// optional early-out for divide-by-zero and signed overflow.
module rv32im_muldiv_unit #(
    parameter int WIDTH         = 32,
    parameter int MUL_LATENCY   = 2,
    parameter int DIV_EARLY_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MUL     = 3'd1;
    localparam logic [2:0] S_DIV     = 3'd2;
    localparam logic [2:0] S_SPECIAL = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam int CNT_W = $clog2(WIDTH + 3);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x, input logic sgn);
        return f_neg_if(x, sgn && x[WIDTH-1]);
    endfunction

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_quo, r_rem, r_result;

    logic w_accept, w_special_in;
    assign o_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign o_valid  = (r_state == S_DONE);
    assign o_result = r_result;
    assign w_accept = i_valid && o_ready;
    assign w_special_in = (i_rs2_data == '0) ||
                          (!i_funct3[0] && i_rs1_data == MOST_NEG && i_rs2_data == '1);

    // Multiply: operands extended to 2*WIDTH so one unsigned multiplier covers all variants
    logic                      w_a_sgn, w_b_sgn;
    logic signed [2*WIDTH-1:0] w_a_x, w_b_x, w_prod;
    logic [WIDTH-1:0]          w_mul_res, w_mul_out;
    assign w_a_sgn   = (r_op != 2'b11) && r_a[WIDTH-1];
    assign w_b_sgn   = (r_op == 2'b01) && r_b[WIDTH-1];
    assign w_a_x     = {{WIDTH{w_a_sgn}}, r_a};
    assign w_b_x     = {{WIDTH{w_b_sgn}}, r_b};
    assign w_prod    = w_a_x * w_b_x;
    assign w_mul_res = (r_op == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

    generate
        if (MUL_LATENCY > 1) begin : g_mul_pipe
            logic [WIDTH-1:0] r_prod_p [MUL_LATENCY-1];
            // ---- product pipeline stages p0 .. p(MUL_LATENCY-2) ----
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MUL_LATENCY - 1; i++) r_prod_p[i] <= '0;
                end else begin
                    r_prod_p[0] <= w_mul_res;
                    for (int i = 1; i < MUL_LATENCY - 1; i++) r_prod_p[i] <= r_prod_p[i-1];
                end
            end
            assign w_mul_out = r_prod_p[MUL_LATENCY-2];
        end else begin : g_mul_comb
            assign w_mul_out = w_mul_res;
        end
    endgenerate

    // Divide: r_quo shifts the dividend magnitude out while quotient bits shift in
    logic             w_div_sgn, w_ge;
    logic [WIDTH-1:0] w_b_mag, w_diff, w_spec_res;
    logic [WIDTH:0]   w_shift;
    assign w_div_sgn = !r_op[0];
    assign w_b_mag   = f_mag(r_b, w_div_sgn);
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, w_b_mag});
    assign w_diff    = w_shift[WIDTH-1:0] - w_b_mag;
    assign w_spec_res = r_op[1] ? ((r_b == '0) ? r_a : '0)
                                : ((r_b == '0) ? '1  : r_a);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_MUL: begin
                    if (r_cnt == CNT_W'(MUL_LATENCY - 1)) begin
                        r_state  <= S_DONE;
                        r_result <= w_mul_out;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SPECIAL: begin
                    // Held two cycles so early-out results keep a fixed 2-cycle latency
                    if (r_cnt == CNT_W'(1)) begin
                        r_state  <= S_DONE;
                        r_result <= w_spec_res;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt < CNT_W'(WIDTH)) begin
                        r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    end else if (r_cnt == CNT_W'(WIDTH)) begin
                        // Zero divisor forces all-ones even for a negative signed dividend
                        r_quo <= (r_b == '0) ? '1
                                 : f_neg_if(r_quo, w_div_sgn && (r_a[WIDTH-1] ^ r_b[WIDTH-1]));
                        r_rem <= f_neg_if(r_rem, w_div_sgn && r_a[WIDTH-1]);
                    end else begin
                        r_state  <= S_DONE;
                        r_result <= r_op[1] ? r_rem : r_quo;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_op  <= i_funct3[1:0];
                        r_a   <= i_rs1_data;
                        r_b   <= i_rs2_data;
                        r_cnt <= '0;
                        r_rem <= '0;
                        r_quo <= f_mag(i_rs1_data, !i_funct3[0]);
                        if (!i_funct3[2])
                            r_state <= S_MUL;
                        else if ((DIV_EARLY_OUT != 0) && w_special_in)
                            r_state <= S_SPECIAL;
                        else
                            r_state <= S_DIV;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32im_muldiv_unit.sv
// Bench for rv32im_muldiv_unit: one instance with divide early-out, one without,
// driven in lockstep and checked against a plain-arithmetic model.
module tb_rv32im_muldiv_unit;

    localparam int W       = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = W + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_rs1 = '0, i_rs2 = '0;
    logic        ready0, ready1, valid0, valid1;
    logic [31:0] res0, res1;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    rv32im_muldiv_unit #(.WIDTH(W), .MUL_LATENCY(MUL_LAT), .DIV_EARLY_OUT(1)) u_dut_eo (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(ready0), .i_funct3(i_funct3),
        .i_rs1_data(i_rs1), .i_rs2_data(i_rs2), .i_flush(i_flush),
        .o_valid(valid0), .o_result(res0));

    rv32im_muldiv_unit #(.WIDTH(W), .MUL_LATENCY(MUL_LAT), .DIV_EARLY_OUT(0)) u_dut_full (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(ready1), .i_funct3(i_funct3),
        .i_rs1_data(i_rs1), .i_rs2_data(i_rs2), .i_flush(i_flush),
        .o_valid(valid1), .o_result(res1));

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        logic [63:0] ua64 = {32'b0, a};
        logic [63:0] ub64 = {32'b0, b};
        logic [63:0] p;
        int          ia = a;
        int          ib = b;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb;     return p[31:0];  end
            3'd1: begin p = sa * sb;     return p[63:32]; end
            3'd2: begin p = sa * ub;     return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b, input int early);
        if (!f3[2]) return MUL_LAT;
        if (early != 0 && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return DIV_LAT;
    endfunction

    task automatic wait_ready();
        int ok = 0;
        for (int c = 0; c < 100 && ok == 0; c++) begin
            if (ready0 && ready1) ok = 1;
            else begin @(posedge clk); #1; end
        end
        total++;
        if (ok == 0) begin
            bad++;
            $display("FAIL wait_ready: got busy want ready");
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        i_valid = 1'b1; i_funct3 = f3; i_rs1 = a; i_rs2 = b;
        @(posedge clk); #1;
        i_valid = 1'b0; i_funct3 = 3'($urandom_range(0, 7)); i_rs1 = $urandom; i_rs2 = $urandom;
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat0 = 0, lat1 = 0;
        logic [31:0] r0 = 'x, r1 = 'x;
        logic busy_ok = 1'b1;
        issue(f3, a, b);
        for (int c = 1; c <= 60 && (lat0 == 0 || lat1 == 0); c++) begin
            @(posedge clk); #1;
            if (lat0 == 0) begin
                if (valid0) begin lat0 = c; r0 = res0; end
                else if (ready0) busy_ok = 1'b0;
            end
            if (lat1 == 0 && valid1) begin lat1 = c; r1 = res1; end
        end
        check({nm, " res_eo"}, r0, exp);
        check({nm, " res_full"}, r1, exp);
        check({nm, " lat_eo"}, 32'(lat0), 32'(exp_lat(f3, a, b, 1)));
        check({nm, " lat_full"}, 32'(lat1), 32'(exp_lat(f3, a, b, 0)));
        check({nm, " busy"}, {31'b0, busy_ok}, 32'd1);
        last_res = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          lat;

        tbl[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
        tbl[1]  = '{3'd1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
        tbl[2]  = '{3'd3, 32'd7,         32'hFFFF_FFFD, 32'h0000_0006};
        tbl[3]  = '{3'd4, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA};
        tbl[4]  = '{3'd6, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE};
        tbl[5]  = '{3'd5, 32'd100,       32'd7,         32'd14};
        tbl[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
        tbl[9]  = '{3'd7, 32'd5,         32'd0,         32'd5};
        tbl[10] = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
        tbl[11] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
        tbl[12] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
        tbl[13] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[14] = '{3'd7, 32'd100,       32'd7,         32'd2};
        tbl[15] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

        repeat (2) @(posedge clk);
        #1;
        check("reset valid", {31'b0, valid0}, 32'd0);
        check("reset ready", {31'b0, ready0}, 32'd1);
        check("reset result", res0, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp);

        // Back-to-back: MULHSU accepted in the DONE cycle of DIVU 9/2
        issue(3'd5, 32'd9, 32'd2);
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(posedge clk); #1;
            seen = valid0;
        end
        check("b2b first valid", {31'b0, seen}, 32'd1);
        check("b2b first res", res0, 32'd4);
        i_valid = 1'b1; i_funct3 = 3'd2; i_rs1 = 32'hFFFF_FFFF; i_rs2 = 32'd2;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (valid0) lat = c;
        end
        check("b2b second lat", 32'(lat), 32'd2);
        check("b2b second res", res0, 32'hFFFF_FFFF);
        last_res = 32'hFFFF_FFFF;

        // Flush ten cycles into a divide, alongside a new request
        issue(3'd4, 32'd1000, 32'd10);
        repeat (9) @(posedge clk);
        #1;
        i_flush = 1'b1; i_valid = 1'b1; i_funct3 = 3'd0; i_rs1 = 32'd6; i_rs2 = 32'd7;
        @(posedge clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        check("flush ready", {31'b0, ready0 & ready1}, 32'd1);
        check("flush result held", res0, last_res);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            seen = seen | valid0 | valid1;
        end
        check("flush no valid", {31'b0, seen}, 32'd0);

        // Flush wins over an accept while idle
        i_flush = 1'b1; i_valid = 1'b1; i_funct3 = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd3;
        @(posedge clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            seen = seen | valid0 | valid1;
        end
        check("idle flush no valid", {31'b0, seen}, 32'd0);
        run_op("mul after flush", 3'd0, 32'd6, 32'd7, 32'd42);

        // Asynchronous reset in the middle of a divide
        issue(3'd5, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst valid", {31'b0, valid0}, 32'd0);
        check("async rst result", res0, 32'd0);
        check("async rst ready", {31'b0, ready0}, 32'd1);
        check("async rst result full", res1, 32'd0);
        #1;
        rst = 1'b0;
        run_op("div after rst", 3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op($sformatf("rnd%0d f3=%0d", i, f3), f3, a, b, ref_model(f3, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
